// File: rtl/vita_rx_framer.sv
// VITA-49 IF-data framer: buffers one packet of time-stamped sample lines in a RAM,
// then emits [transport seq], header, stream id, timestamp and payload on a 36-bit FIFO bus.
module vita_rx_framer #(
  parameter int BASE             = 0,
  parameter int MAXCHAN          = 1,
  parameter int BUF_AW           = 9,
  parameter int USE_TRANS_HEADER = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    clear_seqnum,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [32*MAXCHAN-1:0]   sample_i,
  input  logic [63:0]             time_i,
  input  logic                    sob_i,
  input  logic                    eob_i,
  input  logic                    src_rdy_i,
  output logic                    dst_rdy_o,
  output logic [35:0]             data_o,
  output logic                    src_rdy_o,
  input  logic                    dst_rdy_i,
  output logic [31:0]             current_seqnum,
  output logic [3:0]              state_dbg
);

  // Handshakes: a line moves when src_rdy_i & dst_rdy_o at a rising edge; an output
  // word moves when src_rdy_o & dst_rdy_i. Holding either ready low stalls without loss.

  localparam int LW   = BUF_AW + 1;
  localparam int MAXL = 2 ** BUF_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_TRANS, S_HDR, S_SID, S_SECS, S_TICS, S_TICS2, S_PAYLOAD
  } state_t;

  state_t state, state_nxt;

  logic [1:0]              set_numchan;
  logic [15:0]             set_spp;
  logic [31:0]             set_sid;
  logic [1:0]              numchan_eff, numchan_l;
  logic [LW-1:0]           spp_eff, spp_l;
  logic [31:0]             sid_l;
  logic [63:0]             time_l;
  logic                    sob_l, eob_l;
  logic [LW-1:0]           lines;
  logic [BUF_AW-1:0]       out_line, rd_line;
  logic [1:0]              out_chan;
  logic [3:0]              vita_seq;
  logic [31:0]             seqnum_reg;
  logic [32*MAXCHAN-1:0]   ram [MAXL];
  logic [32*MAXCHAN-1:0]   rd_data;
  logic [31:0]             pay_word, word;
  logic [15:0]             plen;
  logic                    line_acc, word_acc, fill_done, last_word, sof, eof;

  assign line_acc       = src_rdy_i & dst_rdy_o;
  assign word_acc       = src_rdy_o & dst_rdy_i;
  assign fill_done      = (lines == spp_l) | eob_l;
  assign last_word      = ({1'b0, out_line} == lines - LW'(1)) && (out_chan == numchan_l);
  assign current_seqnum = seqnum_reg;
  assign state_dbg      = state;

  // Settings registers and their effective (clamped) values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_numchan <= '0;
      set_spp     <= '0;
      set_sid     <= '0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE))     set_numchan <= set_data[1:0];
      if (set_addr == 8'(BASE + 1)) set_spp     <= set_data[15:0];
      if (set_addr == 8'(BASE + 2)) set_sid     <= set_data;
    end
  end

  always_comb begin
    if (set_spp == '0)             spp_eff = LW'(1);
    else if (32'(set_spp) > MAXL)  spp_eff = LW'(MAXL);
    else                           spp_eff = LW'(set_spp);
    if (set_numchan > 2'(MAXCHAN - 1)) numchan_eff = 2'(MAXCHAN - 1);
    else                               numchan_eff = set_numchan;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = S_FILL;
      S_FILL:    if (fill_done) state_nxt = (USE_TRANS_HEADER != 0) ? S_TRANS : S_HDR;
      S_TRANS:   if (word_acc) state_nxt = S_HDR;
      S_HDR:     if (word_acc) state_nxt = S_SID;
      S_SID:     if (word_acc) state_nxt = S_SECS;
      S_SECS:    if (word_acc) state_nxt = S_TICS;
      S_TICS:    if (word_acc) state_nxt = S_TICS2;
      S_TICS2:   if (word_acc) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (word_acc && last_word) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  // FSM: outputs. FILL stops accepting once the packet is complete, one cycle before leaving.
  always_comb begin
    dst_rdy_o = (state == S_FILL) && !fill_done;
    src_rdy_o = (state != S_IDLE) && (state != S_FILL);
    word      = '0;
    sof       = 1'b0;
    eof       = 1'b0;
    case (state)
      S_TRANS:   begin word = seqnum_reg + 32'd1; sof = 1'b1; end
      S_HDR:     begin
        word = {4'b0001, 2'b00, sob_l, eob_l, 2'b01, 2'b01, vita_seq + 4'd1, plen};
        sof  = (USE_TRANS_HEADER == 0);
      end
      S_SID:     word = sid_l;
      S_SECS:    word = time_l[63:32];
      S_TICS:    word = '0;
      S_TICS2:   word = time_l[31:0];
      S_PAYLOAD: begin word = pay_word; eof = last_word; end
      default:   word = '0;
    endcase
    data_o = {2'b00, eof, sof, word};
  end

  always_comb begin
    plen = 16'(32'(lines) * (32'(numchan_l) + 32'd1) + 32'd5 + 32'(USE_TRANS_HEADER));
  end

  always_comb begin
    pay_word = rd_data[31:0];
    for (int c = 1; c < MAXCHAN; c++)
      if (out_chan == 2'(c)) pay_word = rd_data[32*c +: 32];
  end

  // Read address tracks the line the payload pointer will hold next cycle, so the
  // registered RAM output is always aligned with out_line and words stream back-to-back.
  always_comb begin
    rd_line = out_line;
    if (clear || state == S_IDLE)
      rd_line = '0;
    else if (state == S_PAYLOAD && word_acc && out_chan == numchan_l)
      rd_line = out_line + BUF_AW'(1);
  end

  always_ff @(posedge clk) begin
    if (line_acc) ram[lines[BUF_AW-1:0]] <= sample_i;
    rd_data <= ram[rd_line];
  end

  // Packet datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      numchan_l <= '0;
      spp_l     <= LW'(1);
      sid_l     <= '0;
      time_l    <= '0;
      sob_l     <= 1'b0;
      eob_l     <= 1'b0;
      lines     <= '0;
      out_line  <= '0;
      out_chan  <= '0;
    end else begin
      out_line <= rd_line;
      if (clear) begin
        lines    <= '0;
        eob_l    <= 1'b0;
        out_chan <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            numchan_l <= numchan_eff;
            spp_l     <= spp_eff;
            sid_l     <= set_sid;
            lines     <= '0;
            sob_l     <= 1'b0;
            eob_l     <= 1'b0;
            out_chan  <= '0;
          end
          S_FILL: if (line_acc) begin
            lines <= lines + LW'(1);
            if (lines == '0) begin
              time_l <= time_i;
              sob_l  <= sob_i;
            end
            if (eob_i) eob_l <= 1'b1;
          end
          S_PAYLOAD: if (word_acc) begin
            if (out_chan == numchan_l) out_chan <= '0;
            else                       out_chan <= out_chan + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Sequence counters commit on header acceptance; clear_seqnum takes priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vita_seq   <= 4'hF;
      seqnum_reg <= 32'hFFFF_FFFF;
    end else if (clear_seqnum) begin
      vita_seq   <= 4'hF;
      seqnum_reg <= 32'hFFFF_FFFF;
    end else if (state == S_HDR && word_acc) begin
      vita_seq   <= vita_seq + 4'd1;
      seqnum_reg <= seqnum_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_vita_rx_framer.sv
// Bench for vita_rx_framer: directed packets, expected words queued at issue time and
// compared by an independent monitor on every accepted output word.
module tb_vita_rx_framer;

  localparam int BASE = 16;
  localparam int MAXCHAN = 2;
  localparam int BUF_AW = 3;
  localparam int UTH = 1;

  logic        clk = 0, reset_n = 0, clear = 0, clear_seqnum = 0;
  logic        set_stb = 0;
  logic [7:0]  set_addr = 0;
  logic [31:0] set_data = 0;
  logic [63:0] sample_i = 0, time_i = 0;
  logic        sob_i = 0, eob_i = 0, src_rdy_i = 0, dst_rdy_i = 0;
  logic        dst_rdy_o, src_rdy_o;
  logic [35:0] data_o;
  logic [31:0] current_seqnum;
  logic [3:0]  state_dbg;

  vita_rx_framer #(.BASE(BASE), .MAXCHAN(MAXCHAN), .BUF_AW(BUF_AW), .USE_TRANS_HEADER(UTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .clear_seqnum(clear_seqnum),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sample_i(sample_i), .time_i(time_i), .sob_i(sob_i), .eob_i(eob_i),
    .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o), .data_o(data_o), .src_rdy_o(src_rdy_o),
    .dst_rdy_i(dst_rdy_i), .current_seqnum(current_seqnum), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [35:0] exp_q[$];
  bit   mon_en = 1, src_gaps = 0;
  int   sink_mode = 1;  // 0 stall, 1 always ready, 2 random

  logic [1:0]  m_numchan;
  logic [31:0] m_sid;
  logic [3:0]  m_vseq = 4'hF;
  logic [31:0] m_tseq = 32'hFFFF_FFFF;
  logic [63:0] pk_samp[8];
  logic [63:0] pk_time;

  function automatic logic [35:0] mk(input bit sof, input bit eof, input logic [31:0] w);
    return {2'b00, eof, sof, w};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Sink: drive dst_rdy_i just after each rising edge
  initial forever begin
    @(posedge clk); #1;
    case (sink_mode)
      0:       dst_rdy_i = 1'b0;
      1:       dst_rdy_i = 1'b1;
      default: dst_rdy_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops one expected word per accepted output word
  initial forever begin
    logic [35:0] e;
    @(negedge clk);
    if (reset_n && mon_en && src_rdy_o && dst_rdy_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", data_o);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_fail++;
          $display("FAIL out_word: got %h expected %h", data_o, e);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
  endtask

  task automatic configure(input logic [1:0] nc, input logic [31:0] spp, input logic [31:0] sid);
    set_reg(8'(BASE), {30'd0, nc});
    set_reg(8'(BASE + 1), spp);
    set_reg(8'(BASE + 2), sid);
    m_numchan = nc; m_sid = sid;
    pulse_clear();
  endtask

  task automatic send_line(input logic [63:0] s, input logic [63:0] t, input bit sob, input bit eob);
    int k = 0;
    if (src_gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    src_rdy_i = 1; sample_i = s; time_i = t; sob_i = sob; eob_i = eob;
    @(negedge clk);
    while (!dst_rdy_o && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL line_accept_timeout: got dst_rdy_o=0 expected 1");
    end
    @(posedge clk); #1;
    src_rdy_i = 0; sob_i = 0; eob_i = 0;
  endtask

  task automatic push_packet(input int n, input bit sob, input bit eob);
    logic [15:0] plen;
    m_vseq = m_vseq + 4'd1;
    m_tseq = m_tseq + 32'd1;
    plen = 16'(5 + n * (int'(m_numchan) + 1) + UTH);
    exp_q.push_back(mk(1, 0, m_tseq));
    exp_q.push_back(mk(0, 0, {4'h1, 2'b00, sob, eob, 4'b0101, m_vseq, plen}));
    exp_q.push_back(mk(0, 0, m_sid));
    exp_q.push_back(mk(0, 0, pk_time[63:32]));
    exp_q.push_back(mk(0, 0, 32'd0));
    exp_q.push_back(mk(0, 0, pk_time[31:0]));
    for (int l = 0; l < n; l++)
      for (int c = 0; c <= int'(m_numchan); c++)
        exp_q.push_back(mk(0, (l == n - 1) && (c == int'(m_numchan)), pk_samp[l][32*c +: 32]));
  endtask

  task automatic run_packet(input int n, input bit sob, input bit eob_last, input bit push);
    for (int i = 0; i < n; i++) pk_samp[i] = {$urandom, $urandom};
    pk_time = {$urandom, $urandom};
    if (push) push_packet(n, sob, eob_last);
    for (int i = 0; i < n; i++)
      send_line(pk_samp[i], pk_time + 64'(i), sob && (i == 0), eob_last && (i == n - 1));
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || state_dbg != 4'd1) && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input string name);
    int k = 0;
    @(negedge clk);
    while (state_dbg != s && k < 300) begin @(negedge clk); k++; end
    check(name, state_dbg, s);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_dst_rdy", dst_rdy_o, 0);
    check("rst_src_rdy", src_rdy_o, 0);
    check("rst_data", data_o, 0);
    check("rst_seqnum", current_seqnum, 32'hFFFF_FFFF);
    check("rst_state", state_dbg, 0);
    reset_n = 1;
    @(posedge clk); #1;

    // Packet 1: hand-computed words, numchan=0, spp=4, eob on the last line
    configure(2'd0, 32'd4, 32'h1234_5678);
    m_vseq = 4'h0; m_tseq = 32'd0;
    exp_q.push_back(mk(1, 0, 32'h0000_0000));
    exp_q.push_back(mk(0, 0, 32'h1150_000A));
    exp_q.push_back(mk(0, 0, 32'h1234_5678));
    exp_q.push_back(mk(0, 0, 32'h0000_0001));
    exp_q.push_back(mk(0, 0, 32'h0000_0000));
    exp_q.push_back(mk(0, 0, 32'h0000_0100));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, i == 3, 32'hA000_0000 + 32'(i)));
    for (int i = 0; i < 4; i++)
      send_line({32'hBBBB_0000 + 32'(i), 32'hA000_0000 + 32'(i)}, 64'h1_0000_0100, 0, i == 3);
    @(negedge clk);
    check("lat_n1_src_rdy", src_rdy_o, 0);
    check("lat_n1_dst_rdy", dst_rdy_o, 0);
    @(negedge clk);
    check("lat_n2_src_rdy", src_rdy_o, 1);
    check("lat_n2_sof", data_o[32], 1);
    wait_drain();
    check("seqnum_after_p1", current_seqnum, 32'd0);

    // Two channels: interleaved payload
    configure(2'd1, 32'd3, 32'hCAFE_0002);
    run_packet(3, 1, 0, 1);
    wait_drain();

    // EOB truncation, then sob on the following packet
    configure(2'd0, 32'd8, 32'h0000_0EB0);
    run_packet(3, 0, 1, 1);
    run_packet(8, 1, 0, 1);
    wait_drain();

    // spp clamping: 0 behaves as 1, oversize behaves as 2^BUF_AW
    configure(2'd1, 32'd0, 32'h0000_5150);
    run_packet(1, 0, 0, 1);
    run_packet(1, 1, 0, 1);
    wait_drain();
    configure(2'd0, 32'd100, 32'h0000_5151);
    run_packet(8, 0, 0, 1);
    wait_drain();

    // Random backpressure on both sides, vita seq wraps
    configure(2'd1, 32'd3, 32'hAB12_CD34);
    sink_mode = 2; src_gaps = 1;
    for (int p = 0; p < 20; p++) begin
      if (p % 4 == 2) run_packet($urandom_range(1, 2), p % 5 == 0, 1, 1);
      else            run_packet(3, p % 5 == 0, 0, 1);
    end
    wait_drain();
    sink_mode = 1; src_gaps = 0;

    // clear_seqnum restarts the transport count at 0
    clear_seqnum = 1;
    @(posedge clk); #1;
    clear_seqnum = 0;
    m_vseq = 4'hF; m_tseq = 32'hFFFF_FFFF;
    check("seqnum_cleared", current_seqnum, 32'hFFFF_FFFF);
    run_packet(3, 1, 0, 1);
    run_packet(3, 0, 0, 1);
    wait_drain();
    check("seqnum_after_two", current_seqnum, 32'd1);

    // clear while a complete packet waits at the output
    sink_mode = 0;
    run_packet(3, 0, 0, 0);
    wait_state(4'd2, "stall_in_trans");
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    @(negedge clk);
    check("clear_src_rdy", src_rdy_o, 0);
    check("clear_state", state_dbg, 0);
    check("clear_seq_kept", current_seqnum, 32'd1);
    @(posedge clk); #1;

    // Async reset in the middle of the payload
    mon_en = 0; sink_mode = 1;
    run_packet(3, 0, 0, 0);
    wait_state(4'd8, "reach_payload");
    #2 reset_n = 0;
    #1;
    check("arst_src_rdy", src_rdy_o, 0);
    check("arst_dst_rdy", dst_rdy_o, 0);
    check("arst_data", data_o, 0);
    check("arst_seqnum", current_seqnum, 32'hFFFF_FFFF);
    check("arst_state", state_dbg, 0);
    @(posedge clk); #1;
    reset_n = 1;
    m_vseq = 4'hF; m_tseq = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mon_en = 1;
    configure(2'd1, 32'd3, 32'h0BAD_F00D);
    run_packet(3, 1, 1, 1);
    wait_drain();
    check("seqnum_after_reset", current_seqnum, 32'd0);
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
